// File: rtl/alu_rr_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared definitions for the round-robin ALU scheduler:
//                ALUcontrol op codes and the scheduler state encoding.
//                The SLT/NOR codes are always defined here. They are only
//                accepted as legal operations when ALU_RR_SCHED_EXT_OPS_EN
//                is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // ALUcontrol encodings
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    // Scheduler states: one operation in flight, IDLE -> EXEC -> RESP -> IDLE
    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t EXEC = 2'd1;
    localparam state_t RESP = 2'd2;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_rr_sched_pick.sv
`default_nettype none
// ============================================================================
//  Module      : alu_rr_pick
//  Description : Combinational round-robin picker. It searches requesters
//                starting one past the last grant (i_rr_ptr+1, i_rr_ptr+2, ...
//                modulo NREQ) and returns the first one that is valid.
//  Ports       : i_req_valid  [NREQ]  per-requester valid
//                i_rr_ptr     [IDW]   id of the most recent grant
//                o_grant      [NREQ]  one-hot grant, or zero
//                o_grant_id   [IDW]   index of the granted requester
//                o_any        1       some requester is granted
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_rr_pick #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req_valid,
    input  logic [IDW-1:0]  i_rr_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [IDW-1:0]  o_grant_id,
    output logic            o_any
);

    int             w_idx;
    logic [IDW-1:0] w_sel;

    always_comb begin
        o_grant    = '0;
        o_grant_id = '0;
        o_any      = 1'b0;
        w_idx      = 0;
        w_sel      = '0;
        // The candidate is offset k from the pointer. It wraps explicitly so
        // that NREQ values that are not a power of two still rotate
        // correctly.
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = int'(i_rr_ptr) + k;
            if (w_idx >= NREQ) begin
                w_idx = w_idx - NREQ;
            end
            w_sel = w_idx[IDW-1:0];
            if (!o_any && i_req_valid[w_sel]) begin
                o_grant[w_sel] = 1'b1;
                o_grant_id     = w_sel;
                o_any          = 1'b1;
            end
        end
    end

endmodule : alu_rr_pick
`default_nettype wire

// File: rtl/alu_rr_sched.sv
`default_nettype none
// ============================================================================
//  Module      : alu_rr_sched
//  Description : Shares one W-bit ALU between NREQ requesters. The requester
//                port uses round-robin valid/ready arbitration, and only one
//                operation is in flight at a time. The registered result,
//                zero flag and illegal flag are returned on a valid/ready
//                response channel tagged with the requester id.
//                Latency from accept to resp_valid is 2 cycles. Peak rate is
//                one operation every 3 cycles.
//  Config      : ALU_RR_SCHED_EXT_OPS_EN - when defined, SLT (0111) and
//                NOR (1100) are supported. Otherwise both codes are illegal.
//  Ports       : clk, rst_n (synchronous, active-low)
//                req_valid/req_ready [NREQ], req_op [4*NREQ],
//                req_a/req_b [W*NREQ]  - slice i belongs to requester i
//                resp_valid, resp_ready, resp_id [IDW], resp_result [W],
//                resp_zero, resp_illegal
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_rr_sched
    import alu_pkg::*;
#(
    parameter  int NREQ = 4,
    parameter  int W    = 64,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [4*NREQ-1:0] req_op,
    input  logic [W*NREQ-1:0] req_a,
    input  logic [W*NREQ-1:0] req_b,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [IDW-1:0]    resp_id,
    output logic [W-1:0]      resp_result,
    output logic              resp_zero,
    output logic              resp_illegal
);

    state_t         r_state;
    logic [IDW-1:0] r_rr_ptr;
    logic [3:0]     r_op;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic [IDW-1:0] r_id;

    logic [NREQ-1:0] w_grant;
    logic [IDW-1:0]  w_grant_id;
    logic            w_any;
    logic [W-1:0]    w_result;
    logic            w_illegal;

    alu_rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .i_req_valid (req_valid),
        .i_rr_ptr    (r_rr_ptr),
        .o_grant     (w_grant),
        .o_grant_id  (w_grant_id),
        .o_any       (w_any)
    );

    // The grant is offered only in IDLE. It is also masked while rst_n is
    // low, so that requesters never see an accept during a reset cycle.
    // This holds even before the state register has been reset.
    assign req_ready = (rst_n && (r_state == IDLE)) ? w_grant : '0;

    // Result of the captured operation, registered on the EXEC cycle
    always_comb begin
        w_result  = '0;
        w_illegal = 1'b0;
        case (r_op)
            ALU_AND: w_result = r_a & r_b;
            ALU_OR:  w_result = r_a | r_b;
            ALU_ADD: w_result = r_a + r_b;
            ALU_SUB: w_result = r_a - r_b;
`ifdef ALU_RR_SCHED_EXT_OPS_EN
            ALU_SLT: w_result = {{(W-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
            ALU_NOR: w_result = ~(r_a | r_b);
`endif
            default: w_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_rr_ptr     <= IDW'(NREQ - 1);
            r_op         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_id         <= '0;
            resp_valid   <= 1'b0;
            resp_id      <= '0;
            resp_result  <= '0;
            resp_zero    <= 1'b0;
            resp_illegal <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    // A grant is always a handshake, because the picker
                    // only selects requesters that are valid.
                    if (w_any) begin
                        r_op     <= req_op[w_grant_id*4 +: 4];
                        r_a      <= req_a[w_grant_id*W +: W];
                        r_b      <= req_b[w_grant_id*W +: W];
                        r_id     <= w_grant_id;
                        r_rr_ptr <= w_grant_id;
                        r_state  <= EXEC;
                    end
                end
                EXEC: begin
                    resp_result  <= w_result;
                    resp_zero    <= (w_result == '0);
                    resp_illegal <= w_illegal;
                    resp_id      <= r_id;
                    resp_valid   <= 1'b1;
                    r_state      <= RESP;
                end
                RESP: begin
                    // The resp_* payload stays put after the handshake.
                    // Only the valid flag drops.
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule : alu_rr_sched
`default_nettype wire

// File: tb/tb_alu_rr_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_rr_sched
//  Description : Self-checking bench for alu_rr_sched (NREQ=4, W=64).
//                A negedge monitor holds a transaction-level reference
//                model: the busy flag, the last granted id and a queue of
//                expected responses. Directed and randomized stimulus come
//                from the main initial block.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_rr_sched;

    localparam int NREQ = 4;
    localparam int W    = 64;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [4*NREQ-1:0] req_op;
    logic [W*NREQ-1:0] req_a;
    logic [W*NREQ-1:0] req_b;
    logic              resp_valid;
    logic              resp_ready;
    logic [1:0]        resp_id;
    logic [W-1:0]      resp_result;
    logic              resp_zero;
    logic              resp_illegal;

    alu_rr_sched #(.NREQ(NREQ), .W(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_a        (req_a),
        .req_b        (req_b),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_id      (resp_id),
        .resp_result  (resp_result),
        .resp_zero    (resp_zero),
        .resp_illegal (resp_illegal)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Spec-level op semantics: returns {illegal, zero, result}
    function automatic logic [65:0] ref_alu(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] r;
        logic        ill;
        r   = 64'd0;
        ill = 1'b0;
        case (op)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: r = a + b;
            4'b0110: r = a - b;
`ifdef ALU_RR_SCHED_EXT_OPS_EN
            4'b0111: r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            4'b1100: r = ~(a | b);
`endif
            default: ill = 1'b1;
        endcase
        return {ill, (r == 64'd0), r};
    endfunction

    typedef struct {
        int          id;
        logic [63:0] res;
        logic        zero;
        logic        ill;
    } exp_t;

    exp_t exp_q[$];
    int   grant_log[$];
    int   grant_cyc[$];

    int   cyc        = 0;
    bit   busy       = 0;
    int   acc_cyc    = 0;
    int   last_id    = NREQ - 1;
    bit   rst_seen   = 0;
    int   n_resp     = 0;
    int   resp_cyc   = 0;
    logic [63:0] mon_res;
    logic        mon_zero;
    logic        mon_ill;
    int          mon_id;

    always @(posedge clk) cyc++;

    // Reference model and checker, evaluated at negedge while the inputs
    // are stable
    always @(negedge clk) begin
        logic [NREQ-1:0] exp_rdy;
        logic [65:0]     r;
        exp_t            e;
        int              g;
        if (!rst_n) begin
            check("rst_ready", 64'(req_ready), 64'd0);
            if (rst_seen) begin
                check("rst_valid", 64'(resp_valid), 64'd0);
                check("rst_id", 64'(resp_id), 64'd0);
                check("rst_result", resp_result, 64'd0);
                check("rst_flags", {62'd0, resp_zero, resp_illegal}, 64'd0);
            end
            rst_seen = 1;
            busy     = 0;
            exp_q.delete();
            last_id  = NREQ - 1;
        end else begin
            rst_seen = 0;
            exp_rdy  = '0;
            g        = -1;
            if (!busy) begin
                for (int k = 1; k <= NREQ; k++) begin
                    if (g < 0 && req_valid[(last_id + k) % NREQ]) g = (last_id + k) % NREQ;
                end
                if (g >= 0) exp_rdy[g] = 1'b1;
            end
            check("req_ready", 64'(req_ready), 64'(exp_rdy));
            check("resp_valid", 64'(resp_valid), 64'(busy && (cyc - acc_cyc >= 2)));
            if (resp_valid && exp_q.size() > 0) begin
                check("resp_id", 64'(resp_id), 64'(exp_q[0].id));
                check("resp_result", resp_result, exp_q[0].res);
                check("resp_zero", 64'(resp_zero), 64'(exp_q[0].zero));
                check("resp_illegal", 64'(resp_illegal), 64'(exp_q[0].ill));
            end
            if (resp_valid && resp_ready && busy && exp_q.size() > 0) begin
                mon_res  = exp_q[0].res;
                mon_zero = exp_q[0].zero;
                mon_ill  = exp_q[0].ill;
                mon_id   = exp_q[0].id;
                void'(exp_q.pop_front());
                busy     = 0;
                n_resp++;
                resp_cyc = cyc;
            end
            if (g >= 0) begin
                r      = ref_alu(req_op[g*4 +: 4], req_a[g*W +: W], req_b[g*W +: W]);
                e.id   = g;
                e.res  = r[63:0];
                e.zero = r[64];
                e.ill  = r[65];
                exp_q.push_back(e);
                busy    = 1;
                acc_cyc = cyc;
                last_id = g;
                grant_log.push_back(g);
                grant_cyc.push_back(cyc);
            end
        end
    end

    task automatic do_op(input int id, input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        int n0;
        int t;
        n0             = n_resp;
        req_valid      = '0;
        req_valid[id]  = 1'b1;
        req_op[id*4 +: 4] = op;
        req_a[id*W +: W]  = a;
        req_b[id*W +: W]  = b;
        resp_ready     = 1'b1;
        t = 0;
        while (!busy && t < 20) begin @(posedge clk); #1; t++; end
        req_valid = '0;
        while (n_resp == n0 && t < 40) begin @(posedge clk); #1; t++; end
        if (n_resp == n0) check("op_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy && t < 50) begin @(posedge clk); #1; t++; end
        if (busy) check("idle_timeout", 64'd0, 64'd1);
    endtask

    function automatic logic [63:0] rand_word();
        case ($urandom % 5)
            0: return 64'd0;
            1: return 64'hFFFF_FFFF_FFFF_FFFF;
            2: return 64'($urandom % 16);
            3: return {1'b1, 63'($urandom)};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        logic [3:0]  ops [8];
        logic [63:0] snap_res;
        logic [1:0]  snap_id;
        int          s;
        int          t;
        int          n0;
        ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1111, 4'b0011};

        // Reset with every requester asserting valid
        rst_n      = 1'b0;
        req_valid  = '1;
        resp_ready = 1'b0;
        req_op     = '0;
        req_a      = '0;
        req_b      = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        req_valid = '0;

        // Directed single operations
        do_op(0, 4'b0010, 64'd5, 64'd7);
        check("add_res", mon_res, 64'd12);
        check("add_id", 64'(mon_id), 64'd0);
        check("add_zero", 64'(mon_zero), 64'd0);
        do_op(1, 4'b0110, 64'd3, 64'd3);
        check("sub_res", mon_res, 64'd0);
        check("sub_zero", 64'(mon_zero), 64'd1);
        do_op(1, 4'b0110, 64'd0, 64'd1);
        check("sub_wrap", mon_res, 64'hFFFF_FFFF_FFFF_FFFF);
        do_op(2, 4'b0111, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
`ifdef ALU_RR_SCHED_EXT_OPS_EN
        check("slt_res", mon_res, 64'd1);
        check("slt_ill", 64'(mon_ill), 64'd0);
`else
        check("slt_res", mon_res, 64'd0);
        check("slt_ill", 64'(mon_ill), 64'd1);
        check("slt_zero", 64'(mon_zero), 64'd1);
`endif
        do_op(3, 4'b1100, 64'd0, 64'd0);
`ifdef ALU_RR_SCHED_EXT_OPS_EN
        check("nor_res", mon_res, 64'hFFFF_FFFF_FFFF_FFFF);
`else
        check("nor_ill", 64'(mon_ill), 64'd1);
`endif
        do_op(2, 4'b1111, 64'd9, 64'd9);
        check("bad_ill", 64'(mon_ill), 64'd1);
        check("bad_id", 64'(mon_id), 64'd2);

        // Reset while the operation is in EXEC: no response may follow
        req_valid      = '0;
        req_valid[3]   = 1'b1;
        req_op[12 +: 4] = 4'b0010;
        t = 0;
        while (!busy && t < 20) begin @(posedge clk); #1; t++; end
        req_valid = '0;
        rst_n     = 1'b0;
        n0        = n_resp;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("rst_mid_noresp", 64'(n_resp), 64'(n0));

        // Fairness: all requesters valid and the consumer always ready
        s = grant_log.size();
        for (int i = 0; i < NREQ; i++) req_op[i*4 +: 4] = ops[i];
        req_valid  = '1;
        resp_ready = 1'b1;
        t = 0;
        while (grant_log.size() < s + 5 && t < 100) begin @(posedge clk); #1; t++; end
        if (grant_log.size() < s + 5) begin
            check("fair_timeout", 64'd0, 64'd1);
        end else begin
            for (int i = 0; i < 5; i++) check("fair_id", 64'(grant_log[s+i]), 64'(i % NREQ));
            check("fair_period", 64'(grant_cyc[s+4] - grant_cyc[s]), 64'd12);
            check("fair_step", 64'(grant_cyc[s+1] - grant_cyc[s]), 64'd3);
        end
        req_valid = '0;
        wait_idle();

        // Backpressure: hold resp_ready low for 5 cycles while in RESP
        resp_ready = 1'b0;
        req_valid  = '1;
        t = 0;
        while (!resp_valid && t < 20) begin @(negedge clk); t++; end
        if (!resp_valid) check("bp_timeout", 64'd0, 64'd1);
        snap_res = resp_result;
        snap_id  = resp_id;
        repeat (5) begin
            @(negedge clk);
            check("bp_ready", 64'(req_ready), 64'd0);
            check("bp_result", resp_result, snap_res);
            check("bp_id", 64'(resp_id), 64'(snap_id));
            check("bp_valid", 64'(resp_valid), 64'd1);
        end
        @(posedge clk);
        #1;
        s = grant_cyc.size();
        resp_ready = 1'b1;
        t = 0;
        while (grant_cyc.size() <= s && t < 20) begin @(posedge clk); #1; t++; end
        if (grant_cyc.size() <= s) check("bp_grant_timeout", 64'd0, 64'd1);
        else check("bp_next_grant", 64'(grant_cyc[s] - resp_cyc), 64'd1);
        req_valid = '0;
        wait_idle();

        // Randomized traffic with occasional resets
        for (int n = 0; n < 1500; n++) begin
            @(posedge clk);
            #1;
            rst_n      = ($urandom % 250) != 0;
            req_valid  = NREQ'($urandom);
            resp_ready = ($urandom % 4) != 0;
            for (int i = 0; i < NREQ; i++) begin
                req_op[i*4 +: 4] = ops[$urandom % 8];
                req_a[i*W +: W]  = rand_word();
                req_b[i*W +: W]  = rand_word();
            end
        end
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        req_valid  = '0;
        resp_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("drain_busy", 64'(busy), 64'd0);
        check("drain_queue", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_alu_rr_sched
`default_nettype wire
